// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer bundle for sync_fifo_param
interface sync_fifo_param_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 5
);
    logic                 wr_en;
    logic [WIDTH-1:0]     wdata;
    logic                 rd_en;
    logic                 clr_err;
    logic [WIDTH-1:0]     rdata;
    logic                 rvalid;
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic                 almost_empty;
    logic [CNT_WIDTH-1:0] count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output wr_en, wdata, rd_en, clr_err,
        input  rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, wdata, rd_en, clr_err,
        output rdata, rvalid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO, any depth, sticky errors; SYNC_FIFO_FWFT_EN selects fall-through read
module sync_fifo_param #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int PTR_WIDTH = $clog2(DEPTH),
    parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             res_n,
    sync_fifo_param_if.slave bus
);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_WIDTH-1:0] wr_ptr;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_nxt;
    logic                 full_q;
    logic                 empty_q;
    logic                 afull_q;
    logic                 aempty_q;
    logic                 ovf_q;
    logic                 unf_q;
    logic                 wr_acc;
    logic                 rd_acc;

    assign wr_acc = bus.wr_en && !full_q;
    assign rd_acc = bus.rd_en && !empty_q;

    always_comb begin
        count_nxt = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count_q + CNT_WIDTH'(1);
            2'b01:   count_nxt = count_q - CNT_WIDTH'(1);
            default: count_nxt = count_q;
        endcase
    end

    // Flags come from the next count so they are registered yet never lag occupancy.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            if (wr_acc)
                wr_ptr <= (wr_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : wr_ptr + PTR_WIDTH'(1);
            if (rd_acc)
                rd_ptr <= (rd_ptr == PTR_WIDTH'(DEPTH - 1)) ? '0 : rd_ptr + PTR_WIDTH'(1);
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CNT_WIDTH'(DEPTH));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CNT_WIDTH'(AF_THRESH));
            aempty_q <= (count_nxt <= CNT_WIDTH'(AE_THRESH));
            ovf_q    <= (ovf_q && !bus.clr_err) || (bus.wr_en && full_q);
            unf_q    <= (unf_q && !bus.clr_err) || (bus.rd_en && empty_q);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= bus.wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign bus.rdata  = mem[rd_ptr];
    assign bus.rvalid = !empty_q;
`else
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= rd_acc;
            if (rd_acc)
                rdata_q <= mem[rd_ptr];
        end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = rvalid_q;
`endif

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = afull_q;
    assign bus.almost_empty = aempty_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized/directed bench for sync_fifo_param, DEPTH 16 and 5 side by side
module tb_sync_fifo_param;

    logic clk   = 1'b0;
    logic res_n = 1'b0;

    sync_fifo_param_if #(.WIDTH(8), .CNT_WIDTH(5)) bus0 ();
    sync_fifo_param_if #(.WIDTH(8), .CNT_WIDTH(3)) bus1 ();

    sync_fifo_param #(.WIDTH(8), .DEPTH(16)) dut0 (
        .clk(clk), .res_n(res_n), .bus(bus0)
    );
    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) dut1 (
        .clk(clk), .res_n(res_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    // Reference: a queue per FIFO plus sticky flags and the last popped word.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int         dep [2] = '{16, 5};
    int         afth[2] = '{14, 4};
    int         aeth[2] = '{2, 1};
    bit         m_ovf[2];
    bit         m_unf[2];
    bit         m_rv [2];
    logic [7:0] m_rd [2];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            m_ovf[d] = 1'b0;
            m_unf[d] = 1'b0;
            m_rv[d]  = 1'b0;
            m_rd[d]  = 8'h00;
        end
    endtask

    task automatic model_step(input int d, input bit w, input logic [7:0] wd, input bit r, input bit clr);
        int sz;
        bit f, e;
        sz = (d == 0) ? q0.size() : q1.size();
        f  = (sz == dep[d]);
        e  = (sz == 0);
        if (r && !e) begin
            if (d == 0) m_rd[d] = q0.pop_front();
            else        m_rd[d] = q1.pop_front();
        end
        if (w && !f) begin
            if (d == 0) q0.push_back(wd);
            else        q1.push_back(wd);
        end
        m_rv[d]  = r && !e;
        m_ovf[d] = (m_ovf[d] && !clr) || (w && f);
        m_unf[d] = (m_unf[d] && !clr) || (r && e);
    endtask

    task automatic check_dut(input int d);
        int         sz;
        logic [7:0] front;
        logic [4:0] o_cnt;
        logic       o_full, o_empty, o_af, o_ae, o_ovf, o_unf, o_rv;
        logic [7:0] o_rd;
        if (d == 0) begin
            sz = q0.size();
            front = (sz != 0) ? q0[0] : 8'h00;
            o_cnt = bus0.count; o_full = bus0.full; o_empty = bus0.empty;
            o_af = bus0.almost_full; o_ae = bus0.almost_empty;
            o_ovf = bus0.overflow; o_unf = bus0.underflow;
            o_rv = bus0.rvalid; o_rd = bus0.rdata;
        end else begin
            sz = q1.size();
            front = (sz != 0) ? q1[0] : 8'h00;
            o_cnt = {2'b00, bus1.count}; o_full = bus1.full; o_empty = bus1.empty;
            o_af = bus1.almost_full; o_ae = bus1.almost_empty;
            o_ovf = bus1.overflow; o_unf = bus1.underflow;
            o_rv = bus1.rvalid; o_rd = bus1.rdata;
        end
        chk($sformatf("d%0d count", d), 32'(o_cnt), 32'(sz));
        chk($sformatf("d%0d full", d), 32'(o_full), 32'(sz == dep[d]));
        chk($sformatf("d%0d empty", d), 32'(o_empty), 32'(sz == 0));
        chk($sformatf("d%0d almost_full", d), 32'(o_af), 32'(sz >= afth[d]));
        chk($sformatf("d%0d almost_empty", d), 32'(o_ae), 32'(sz <= aeth[d]));
        chk($sformatf("d%0d overflow", d), 32'(o_ovf), 32'(m_ovf[d]));
        chk($sformatf("d%0d underflow", d), 32'(o_unf), 32'(m_unf[d]));
`ifdef SYNC_FIFO_FWFT_EN
        chk($sformatf("d%0d rvalid", d), 32'(o_rv), 32'(sz != 0));
        if (sz != 0)
            chk($sformatf("d%0d rdata", d), 32'(o_rd), 32'(front));
`else
        chk($sformatf("d%0d rvalid", d), 32'(o_rv), 32'(m_rv[d]));
        chk($sformatf("d%0d rdata", d), 32'(o_rd), 32'(m_rd[d]));
`endif
    endtask

    task automatic step(input bit w, input logic [7:0] wd, input bit r, input bit clr);
        bus0.wr_en = w; bus0.wdata = wd; bus0.rd_en = r; bus0.clr_err = clr;
        bus1.wr_en = w; bus1.wdata = wd; bus1.rd_en = r; bus1.clr_err = clr;
        model_step(0, w, wd, r, clr);
        model_step(1, w, wd, r, clr);
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
    endtask

    initial begin
        bus0.wr_en = 0; bus0.wdata = 0; bus0.rd_en = 0; bus0.clr_err = 0;
        bus1.wr_en = 0; bus1.wdata = 0; bus1.rd_en = 0; bus1.clr_err = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_dut(0);
        check_dut(1);
        res_n = 1'b1;

        // Fill with 0x01..0x10, then drain in order.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
        chk("d0 filled count", 32'(bus0.count), 32'd16);
        chk("d0 filled full", 32'(bus0.full), 32'd1);
        for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        chk("d0 drained empty", 32'(bus0.empty), 32'd1);

        // Full FIFO with simultaneous read/write drops the write.
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b1, 1'b0);
        chk("d0 full rw count", 32'(bus0.count), 32'd15);
        chk("d0 full rw overflow", 32'(bus0.overflow), 32'd1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        chk("d0 clr overflow", 32'(bus0.overflow), 32'd0);

        // Empty FIFO with simultaneous read/write drops the read.
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        chk("d0 empty rw underflow", 32'(bus0.underflow), 32'd1);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Sustained read+write at count 3; the depth-5 pointers wrap repeatedly.
        for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b1, 1'b0);
        chk("d1 steady count", 32'(bus1.count), 32'd3);
        for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic, write-heavy then read-heavy.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 70 : 30;
            step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp),
                 $urandom_range(0, 99) < 5);
        end

        // Asynchronous reset mid-burst at count 7.
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
        #2;
        res_n = 1'b0;
        bus0.wr_en = 0; bus0.rd_en = 0; bus1.wr_en = 0; bus1.rd_en = 0;
        #1;
        model_reset();
        check_dut(0);
        check_dut(1);
        #1;
        res_n = 1'b1;
        step(1'b1, 8'h9E, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Single word into an empty FIFO, shown then popped.
        step(1'b1, 8'h3C, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO, the single-clock counterpart of our FIFO buffering blocks. It generalises data width, depth (any depth, not only powers of two), almost-full/almost-empty thresholds and a live occupancy count. Overflow/underflow reporting is sticky with an explicit clear. It sits between a producer and a consumer in the same clock domain and is the default buffer for new datapaths.

## Interface
Parameters:
- WIDTH, 8, data word width in bits (>=1)
- DEPTH, 16, number of entries (>=2, any integer)
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
- PTR_WIDTH, $clog2(DEPTH), pointer width
- CNT_WIDTH, $clog2(DEPTH+1), count width

Ports:
- clk  in  1  single clock; everything on rising edge
- res_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wdata  in  WIDTH  write data
- rd_en  in  1  read request
- rdata  out  WIDTH  read data
- rvalid  out  1  rdata holds a freshly popped word
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  CNT_WIDTH  current occupancy
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- clr_err  in  1  synchronous clear of overflow/underflow

## Operation
- Write accepted iff wr_en && !full. Read accepted iff rd_en && !empty. Flags are evaluated on registered state at the edge.
- Accepted write: mem[wr_ptr] <= wdata. wr_ptr advances, wrapping DEPTH-1 -> 0 explicitly (no power-of-two assumption).
- Accepted read: rdata <= mem[rd_ptr]. rd_ptr advances with the same wrap rule.
- count: +1 on write-only, -1 on read-only, unchanged when both or neither are accepted.
- Full flag and registered full, simultaneous rd_en+wr_en: read accepted, write rejected, overflow set, count -> DEPTH-1.
- Empty flag, simultaneous rd_en+wr_en: write accepted, read rejected, underflow set, count -> 1.
- Otherwise simultaneous rd_en+wr_en: both accepted; pointers wrap independently.
- full, empty, almost_full and almost_empty are registered and derived from next count. They never glitch.
- overflow/underflow: set by a rejected request, held until clr_err. If clr_err and a new error occur in the same cycle, the flag remains set.
- Rejected requests change no pointer, memory, count or rdata.
- Storage is not reset. Contents after reset are don't-care and never readable.

## Timing
- Reset (res_n low, asynchronous) clears:
  - wr_ptr, rd_ptr, count, rdata and rvalid to 0
  - full, almost_full, overflow and underflow to 0
  - empty to 1, and almost_empty to 1
- Release of res_n is synchronised by the integrator. Reset mid-operation discards all contents immediately.
- Read latency: read accepted at edge N gives rdata valid and rvalid=1 during cycle N+1. rvalid is 0 in any cycle not preceded by an accepted read. rdata holds its last value otherwise.
- Write-to-read: word written at edge N deasserts empty after edge N. A read can be accepted at edge N+1, and data appears in cycle N+2.
- Back-to-back reads/writes are sustained at one per cycle each.

## Configuration
- SYNC_FIFO_FWFT_EN defined: first-word fall-through mode.
  - rdata = mem[rd_ptr] combinationally, and rvalid = !empty.
  - rd_en acts as pop/acknowledge of the shown word.
  - A word written into an empty FIFO at edge N is visible on rdata with rvalid=1 in cycle N+1.
  - The rdata reset value is don't-care while rvalid=0.
- Undefined: standard registered-read mode as described above.
- Flag, count and error behaviour are identical in both modes.

## Test plan
- Reset, then write 0x01..0x10 (DEPTH=16) on consecutive cycles -> count 16, full=1, almost_full=1 from count 14. Then read all -> rdata 0x01..0x10 in order, each one cycle after its rd_en, ending with empty=1.
- Full FIFO, wr_en+rd_en together with wdata=0xAA -> read returns the oldest word, 0xAA is dropped, overflow=1, count=15. Then clr_err -> overflow=0.
- Empty FIFO, wr_en+rd_en together with wdata=0x55 -> underflow=1, count=1, rvalid=0. Next cycle rd_en -> 0x55.
- DEPTH=5: continuous simultaneous read/write over 20 cycles at count 3 -> pointers wrap 4->0, data order preserved, count stays 3.
- Assert res_n low mid-burst at count 7 -> outputs take reset values immediately. A subsequent single write/read returns the new word.
- With SYNC_FIFO_FWFT_EN: write 0x3C to an empty FIFO -> rdata=0x3C, rvalid=1 the next cycle with no rd_en. Then rd_en -> empty=1, rvalid=0.
